// File: rtl/sound_arbiter.sv
// sound_arbiter: shares one tone generator between four requesters.
//
// Each requester posts a {duration ms, half period us} pair into its own slot;
// the arbiter grants one buffered tone at a time, hands its parameters to the
// generator and reports the grant and its completion back to the requester.
//
// Ports:
//   Clock, Reset       clock, asynchronous active-low reset
//   Req_i, Cancel_i    per-requester post / drop of a pending tone
//   Duration_ms_i      lane n at [16n+15:16n], tone length in ms
//   HalfPeriod_us_i    lane n at [16n+15:16n], half period in us
//   Pending_o          tone buffered and waiting, per requester
//   Grant_o            one-hot owner of the generator
//   Done_o             one-cycle completion pulse of the granted tone
//   Request_o          one-cycle start pulse to the generator
//   Duration_ms_o      tone length presented to the generator
//   HalfPeriod_us_o    half period presented to the generator
//   GenBusy_i          generator busy, status only
//   GenDone_i          generator completion pulse, honoured only in WAIT_GEN
//
// Build option: SOUND_ARBITER_FIXED_PRIORITY_EN selects lowest-index-wins
// arbitration instead of round-robin.
module sound_arbiter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req_i,
  input  logic [3:0]  Cancel_i,
  input  logic [63:0] Duration_ms_i,
  input  logic [63:0] HalfPeriod_us_i,
  output logic [3:0]  Pending_o,
  output logic [3:0]  Grant_o,
  output logic [3:0]  Done_o,
  output logic        Request_o,
  output logic [15:0] Duration_ms_o,
  output logic [15:0] HalfPeriod_us_o,
  input  logic        GenBusy_i,
  input  logic        GenDone_i
);
  typedef enum logic [1:0] {IDLE, WAIT_GEN, DONE} state_t;
  state_t      state_q;
  logic [3:0]  pend_q, pend_d, grant_q, done_q;
  logic [15:0] dur_q [4];
  logic [15:0] hp_q [4];
  logic        req_q;
  logic [15:0] dur_o_q, hp_o_q;
  logic [1:0]  win_d, zero_q;
  logic        grant_now, unused_gen_busy;
`ifndef SOUND_ARBITER_FIXED_PRIORITY_EN
  logic [1:0]  last_q, idx;
`endif
  assign unused_gen_busy = GenBusy_i;
  always_comb begin
    win_d = '0;
`ifdef SOUND_ARBITER_FIXED_PRIORITY_EN
    for (int i = 3; i >= 0; i--)
      if (pend_q[i]) win_d = 2'(i);
`else
    // Scan last+4 (=last) down to last+1 so the nearest pending requester after last wins.
    idx = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (pend_q[idx]) win_d = idx;
    end
`endif
  end
  always_comb begin
    grant_now = (state_q == IDLE) && |pend_q;
    for (int i = 0; i < 4; i++)
      pend_d[i] = Cancel_i[i] ? 1'b0 : Req_i[i] ? 1'b1 : (grant_now && win_d == 2'(i)) ? 1'b0 : pend_q[i];
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dur_q[i] <= '0;
        hp_q[i]  <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < 4; i++)
        if (Req_i[i]) begin
          dur_q[i] <= Duration_ms_i[16*i +: 16];
          hp_q[i]  <= HalfPeriod_us_i[16*i +: 16];
        end
    end
  end
  // Zero-length tones bypass the generator; zero_q paces them so Done_o
  // lands two edges after the grant edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      req_q   <= 1'b0;
      dur_o_q <= '0;
      hp_o_q  <= '0;
      zero_q  <= '0;
`ifndef SOUND_ARBITER_FIXED_PRIORITY_EN
      last_q  <= 2'd3;
`endif
    end else begin
      req_q  <= 1'b0;
      done_q <= '0;
      case (state_q)
        IDLE: if (grant_now) begin
          dur_o_q <= dur_q[win_d];
          hp_o_q  <= hp_q[win_d];
          grant_q <= 4'b1 << win_d;
`ifndef SOUND_ARBITER_FIXED_PRIORITY_EN
          // last_q is only read in IDLE, so committing it at grant equals committing at completion.
          last_q  <= win_d;
`endif
          if (dur_q[win_d] != '0) begin
            req_q   <= 1'b1;
            state_q <= WAIT_GEN;
          end else begin
            zero_q  <= 2'd2;
            state_q <= DONE;
          end
        end
        WAIT_GEN: if (GenDone_i) begin
          done_q  <= grant_q;
          grant_q <= '0;
          state_q <= DONE;
        end
        DONE: begin
          zero_q <= zero_q == 2'd0 ? 2'd0 : zero_q - 2'd1;
          if (zero_q == 2'd1) begin
            done_q  <= grant_q;
            grant_q <= '0;
          end
          if (zero_q == 2'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Pending_o       = pend_q;
  assign Grant_o         = grant_q;
  assign Done_o          = done_q;
  assign Request_o       = req_q;
  assign Duration_ms_o   = dur_o_q;
  assign HalfPeriod_us_o = hp_o_q;
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_sound_arbiter;
  logic        Clock = 1'b0, Reset = 1'b0;
  logic [3:0]  Req_i = '0, Cancel_i = '0;
  logic [63:0] Duration_ms_i = '0, HalfPeriod_us_i = '0;
  logic        GenBusy_i = 1'b0, GenDone_i = 1'b0;
  logic [3:0]  Pending_o, Grant_o, Done_o;
  logic        Request_o;
  logic [15:0] Duration_ms_o, HalfPeriod_us_o;
  int n_vec = 0, n_err = 0;
  logic [3:0]  m_pend, e_grant, e_done;
  logic        e_req;
  logic [15:0] e_dur, e_hp;
  logic [15:0] m_dur [4];
  logic [15:0] m_hp [4];
  int m_owner, m_last, m_zero;
  bit m_cool;
  sound_arbiter dut (
    .Clock(Clock), .Reset(Reset), .Req_i(Req_i), .Cancel_i(Cancel_i),
    .Duration_ms_i(Duration_ms_i), .HalfPeriod_us_i(HalfPeriod_us_i),
    .Pending_o(Pending_o), .Grant_o(Grant_o), .Done_o(Done_o), .Request_o(Request_o),
    .Duration_ms_o(Duration_ms_o), .HalfPeriod_us_o(HalfPeriod_us_o),
    .GenBusy_i(GenBusy_i), .GenDone_i(GenDone_i)
  );
  always #5 Clock = ~Clock;
  function automatic logic [63:0] lane(input int n, input logic [15:0] v);
    return 64'(v) << (16 * n);
  endfunction
  task automatic model_reset();
    m_pend = '0; e_grant = '0; e_done = '0; e_req = 1'b0; e_dur = '0; e_hp = '0;
    for (int i = 0; i < 4; i++) begin m_dur[i] = '0; m_hp[i] = '0; end
    m_owner = -1; m_last = 3; m_zero = 0; m_cool = 0;
  endtask
  // One clock edge of the arbiter at transaction level: who owns the
  // generator, how long a skipped tone still has to go, and the dead cycle
  // that follows every completion.
  task automatic model_edge(input logic [3:0] r, c, input logic [63:0] d, h, input logic g);
    int w;
    w = -1;
    e_done = '0;
    e_req = 1'b0;
    if (m_cool) m_cool = 0;
    else if (m_owner < 0) begin
`ifdef SOUND_ARBITER_FIXED_PRIORITY_EN
      for (int i = 0; i < 4; i++) if (w < 0 && m_pend[i]) w = i;
`else
      for (int i = 1; i <= 4; i++) if (w < 0 && m_pend[(m_last + i) % 4]) w = (m_last + i) % 4;
`endif
      if (w >= 0) begin
        m_owner = w; e_grant = 4'b1 << w; e_dur = m_dur[w]; e_hp = m_hp[w];
        if (m_dur[w] != 0) e_req = 1'b1; else m_zero = 2;
      end
    end else if (m_zero == 2) m_zero = 1;
    else if (m_zero == 1 || g) begin
      e_done = e_grant; e_grant = '0; m_last = m_owner; m_owner = -1; m_zero = 0; m_cool = 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (c[i]) m_pend[i] = 1'b0; else if (r[i]) m_pend[i] = 1'b1; else if (i == w) m_pend[i] = 1'b0;
      if (r[i]) begin m_dur[i] = d[16*i +: 16]; m_hp[i] = h[16*i +: 16]; end
    end
  endtask
  task automatic step(input logic [3:0] r, c, input logic [63:0] d, h, input logic g);
    Req_i = r; Cancel_i = c; Duration_ms_i = d; HalfPeriod_us_i = h; GenDone_i = g;
    @(posedge Clock);
    if (Reset) model_edge(r, c, d, h, g); else model_reset();
    #1;
    Req_i = '0; Cancel_i = '0; GenDone_i = 1'b0;
  endtask
  task automatic idle();
    step(4'b0, 4'b0, 64'b0, 64'b0, 1'b0);
  endtask
  task automatic do_reset();
    #2 Reset = 1'b0;
    model_reset();
    #3 Reset = 1'b1;
  endtask
  task automatic test_reset();
    model_reset();
    #3;
    n_vec += 6;
    if (Pending_o !== 4'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0000", Pending_o); end
    if (Grant_o !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", Grant_o); end
    if (Done_o !== 4'b0) begin n_err++; $display("FAIL reset_done: got %b want 0000", Done_o); end
    if (Request_o !== 1'b0) begin n_err++; $display("FAIL reset_request: got %b want 0", Request_o); end
    if (Duration_ms_o !== 16'd0) begin n_err++; $display("FAIL reset_dur: got %0d want 0", Duration_ms_o); end
    if (HalfPeriod_us_o !== 16'd0) begin n_err++; $display("FAIL reset_hp: got %0d want 0", HalfPeriod_us_o); end
    Reset = 1'b1;
  endtask
  task automatic test_single_tone();
    int nreq;
    step(4'b0010, 4'b0, lane(1, 16'd1000), lane(1, 16'd500), 1'b0);
    n_vec += 2;
    if (Pending_o !== 4'b0010) begin n_err++; $display("FAIL single_pending: got %b want 0010", Pending_o); end
    if (Grant_o !== 4'b0) begin n_err++; $display("FAIL single_early_grant: got %b want 0000", Grant_o); end
    idle();
    nreq = int'(Request_o);
    n_vec += 5;
    if (Grant_o !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b want 0010", Grant_o); end
    if (Request_o !== 1'b1) begin n_err++; $display("FAIL single_request: got %b want 1", Request_o); end
    if (Duration_ms_o !== 16'd1000) begin n_err++; $display("FAIL single_dur: got %0d want 1000", Duration_ms_o); end
    if (HalfPeriod_us_o !== 16'd500) begin n_err++; $display("FAIL single_hp: got %0d want 500", HalfPeriod_us_o); end
    if (Pending_o !== 4'b0) begin n_err++; $display("FAIL single_pend_clr: got %b want 0000", Pending_o); end
    for (int i = 0; i < 4; i++) begin idle(); nreq += int'(Request_o); end
    n_vec++;
    if (Grant_o !== 4'b0010) begin n_err++; $display("FAIL single_grant_hold: got %b want 0010", Grant_o); end
    step(4'b0, 4'b0, 64'b0, 64'b0, 1'b1);
    nreq += int'(Request_o);
    n_vec += 2;
    if (Done_o !== 4'b0010) begin n_err++; $display("FAIL single_done: got %b want 0010", Done_o); end
    if (Grant_o !== 4'b0) begin n_err++; $display("FAIL single_grant_rel: got %b want 0000", Grant_o); end
    idle();
    nreq += int'(Request_o);
    n_vec += 2;
    if (Done_o !== 4'b0) begin n_err++; $display("FAIL single_done_pulse: got %b want 0000", Done_o); end
    if (nreq !== 1) begin n_err++; $display("FAIL single_request_count: got %0d want 1", nreq); end
  endtask
  task automatic test_round_robin();
    do_reset();
    step(4'b1111, 4'b0, {16'd40, 16'd30, 16'd20, 16'd10}, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 6 && Grant_o == 4'b0; t++) idle();
      n_vec += 2;
      if (Grant_o !== 4'(1 << k)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, Grant_o, 4'(1 << k)); end
      if (Duration_ms_o !== 16'(10 * (k + 1))) begin n_err++; $display("FAIL rr_dur%0d: got %0d want %0d", k, Duration_ms_o, 10 * (k + 1)); end
      if (k == 3) step(4'b0010, 4'b0, lane(1, 16'd99), lane(1, 16'd9), 1'b0);
      step(4'b0, 4'b0, 64'b0, 64'b0, 1'b1);
      n_vec++;
      if (Done_o !== 4'(1 << k)) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", k, Done_o, 4'(1 << k)); end
      idle();
    end
    for (int t = 0; t < 6 && Grant_o == 4'b0; t++) idle();
    n_vec += 2;
    if (Grant_o !== 4'b0010) begin n_err++; $display("FAIL rr_regrant: got %b want 0010", Grant_o); end
    if (Duration_ms_o !== 16'd99) begin n_err++; $display("FAIL rr_regrant_dur: got %0d want 99", Duration_ms_o); end
    step(4'b0, 4'b0, 64'b0, 64'b0, 1'b1);
    idle();
  endtask
  task automatic test_zero_duration();
    step(4'b0100, 4'b0, lane(2, 16'd0), lane(2, 16'd77), 1'b0);
    idle();
    n_vec += 3;
    if (Grant_o !== 4'b0100) begin n_err++; $display("FAIL zero_grant: got %b want 0100", Grant_o); end
    if (Request_o !== 1'b0) begin n_err++; $display("FAIL zero_request: got %b want 0", Request_o); end
    if (HalfPeriod_us_o !== 16'd77) begin n_err++; $display("FAIL zero_hp: got %0d want 77", HalfPeriod_us_o); end
    step(4'b0, 4'b0, 64'b0, 64'b0, 1'b1);
    n_vec += 2;
    if (Done_o !== 4'b0) begin n_err++; $display("FAIL zero_done_early: got %b want 0000", Done_o); end
    if (Request_o !== 1'b0) begin n_err++; $display("FAIL zero_request2: got %b want 0", Request_o); end
    idle();
    n_vec += 2;
    if (Done_o !== 4'b0100) begin n_err++; $display("FAIL zero_done: got %b want 0100", Done_o); end
    if (Grant_o !== 4'b0) begin n_err++; $display("FAIL zero_grant_rel: got %b want 0000", Grant_o); end
    idle();
    n_vec++;
    if (Done_o !== 4'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b want 0000", Done_o); end
  endtask
  task automatic test_cancel();
    logic [3:0] seen;
    step(4'b0001, 4'b0, lane(0, 16'd50), lane(0, 16'd5), 1'b0);
    idle();
    step(4'b1000, 4'b0, lane(3, 16'd60), lane(3, 16'd6), 1'b0);
    n_vec++;
    if (Pending_o !== 4'b1000) begin n_err++; $display("FAIL cancel_pend_set: got %b want 1000", Pending_o); end
    step(4'b1000, 4'b1001, lane(3, 16'd61), lane(3, 16'd7), 1'b0);
    n_vec += 2;
    if (Pending_o !== 4'b0) begin n_err++; $display("FAIL cancel_pend_clr: got %b want 0000", Pending_o); end
    if (Grant_o !== 4'b0001) begin n_err++; $display("FAIL cancel_playing: got %b want 0001", Grant_o); end
    step(4'b0, 4'b0, 64'b0, 64'b0, 1'b1);
    n_vec++;
    if (Done_o !== 4'b0001) begin n_err++; $display("FAIL cancel_done: got %b want 0001", Done_o); end
    seen = '0;
    for (int i = 0; i < 5; i++) begin idle(); seen |= Grant_o; end
    n_vec++;
    if (seen !== 4'b0) begin n_err++; $display("FAIL cancel_no_grant: got %b want 0000", seen); end
  endtask
  task automatic test_reset_mid();
    logic [3:0] seen;
    step(4'b0001, 4'b0, lane(0, 16'd70), lane(0, 16'd8), 1'b0);
    idle();
    step(4'b0110, 4'b0, lane(1, 16'd11) | lane(2, 16'd22), lane(1, 16'd1) | lane(2, 16'd2), 1'b0);
    #2 Reset = 1'b0;
    model_reset();
    #1;
    n_vec += 4;
    if (Pending_o !== 4'b0) begin n_err++; $display("FAIL rstmid_pending: got %b want 0000", Pending_o); end
    if (Grant_o !== 4'b0) begin n_err++; $display("FAIL rstmid_grant: got %b want 0000", Grant_o); end
    if (Duration_ms_o !== 16'd0) begin n_err++; $display("FAIL rstmid_dur: got %0d want 0", Duration_ms_o); end
    if (HalfPeriod_us_o !== 16'd0) begin n_err++; $display("FAIL rstmid_hp: got %0d want 0", HalfPeriod_us_o); end
    @(posedge Clock);
    #2 Reset = 1'b1;
    seen = '0;
    for (int i = 0; i < 5; i++) begin idle(); seen |= Grant_o | Pending_o; end
    n_vec++;
    if (seen !== 4'b0) begin n_err++; $display("FAIL rstmid_quiet: got %b want 0000", seen); end
    step(4'b0100, 4'b0, lane(2, 16'd33), lane(2, 16'd3), 1'b0);
    idle();
    n_vec += 2;
    if (Grant_o !== 4'b0100) begin n_err++; $display("FAIL rstmid_new_grant: got %b want 0100", Grant_o); end
    if (Duration_ms_o !== 16'd33) begin n_err++; $display("FAIL rstmid_new_dur: got %0d want 33", Duration_ms_o); end
    step(4'b0, 4'b0, 64'b0, 64'b0, 1'b1);
    idle();
  endtask
`ifdef SOUND_ARBITER_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    logic [3:0] seen;
    do_reset();
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0101, 4'b0, lane(0, 16'd5) | lane(2, 16'd6), 64'd1, 1'($urandom_range(1)));
      seen |= Grant_o;
    end
    n_vec += 2;
    if (seen[2] !== 1'b0) begin n_err++; $display("FAIL fixed_starve: got %b want 0", seen[2]); end
    if (seen[0] !== 1'b1) begin n_err++; $display("FAIL fixed_win0: got %b want 1", seen[0]); end
  endtask
`endif
  task automatic test_random();
    logic [3:0] r, c;
    logic [63:0] d, h;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(499) == 0) do_reset();
      for (int i = 0; i < 4; i++) begin
        r[i] = $urandom_range(7) == 0;
        c[i] = $urandom_range(15) == 0;
        d[16*i +: 16] = $urandom_range(3) == 0 ? 16'd0 : 16'($urandom);
        h[16*i +: 16] = 16'($urandom);
      end
      GenBusy_i = 1'($urandom);
      step(r, c, d, h, $urandom_range(2) == 0);
      n_vec += 6;
      if (Pending_o !== m_pend) begin n_err++; $display("FAIL rnd_pending @%0d: got %b want %b", cyc, Pending_o, m_pend); end
      if (Grant_o !== e_grant) begin n_err++; $display("FAIL rnd_grant @%0d: got %b want %b", cyc, Grant_o, e_grant); end
      if (Done_o !== e_done) begin n_err++; $display("FAIL rnd_done @%0d: got %b want %b", cyc, Done_o, e_done); end
      if (Request_o !== e_req) begin n_err++; $display("FAIL rnd_request @%0d: got %b want %b", cyc, Request_o, e_req); end
      if (Duration_ms_o !== e_dur) begin n_err++; $display("FAIL rnd_dur @%0d: got %0d want %0d", cyc, Duration_ms_o, e_dur); end
      if (HalfPeriod_us_o !== e_hp) begin n_err++; $display("FAIL rnd_hp @%0d: got %0d want %0d", cyc, HalfPeriod_us_o, e_hp); end
    end
  endtask
  initial begin
    test_reset();
    test_single_tone();
    test_round_robin();
    test_zero_duration();
    test_cancel();
    test_reset_mid();
`ifdef SOUND_ARBITER_FIXED_PRIORITY_EN
    test_fixed_priority();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Sound arbiter that shares one sound generator between four independent requesters, for example a melody player, a keypad click and an alarm beeper. Each requester posts a tone as a duration/half-period pair. The arbiter buffers one tone per requester and picks a winner round-robin. It drives the generator's request/parameter inputs and returns per-requester grant and completion indications. It sits between the tone sources and the single generator that drives the speaker pin.

## Interface
Parameters: none. The requester count is fixed at 4.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- Req_i  in  4  per-requester tone request, sampled every cycle (level or pulse)
- Cancel_i  in  4  per-requester drop of a pending (not yet granted) tone
- Duration_ms_i  in  64  requester n at bits [16n+15:16n], tone length in ms
- HalfPeriod_us_i  in  64  requester n at bits [16n+15:16n], half period in µs
- Pending_o  out  4  tone buffered and waiting for requester n
- Grant_o  out  4  one-hot; requester n's tone is currently owned by the generator
- Done_o  out  4  one-cycle pulse when requester n's granted tone finishes
- Request_o  out  1  one-cycle start pulse to the generator
- Duration_ms_o  out  16  tone length presented to the generator
- HalfPeriod_us_o  out  16  half period presented to the generator
- GenBusy_i  in  1  generator busy; status only, not used for sequencing
- GenDone_i  in  1  generator one-cycle completion pulse

## Operation
- Slot buffer: one 32-bit slot per requester holds the duration and half period, plus a pending bit.
  - Req_i[n] sampled high captures requester n's inputs into slot n and sets Pending[n].
  - A repeated Req_i while the tone is pending overwrites the buffered parameters.
- Cancel_i[n] clears Pending[n].
  - Cancel and Req on the same edge: Cancel wins and the slot is left empty.
  - Cancel has no effect on a granted tone.
- FSM states: IDLE, WAIT_GEN, DONE.
- IDLE, with any pending bit set:
  - Select the winner W.
  - Copy slot W to Duration_ms_o/HalfPeriod_us_o.
  - Clear Pending[W] and set Grant_o[W].
  - If the duration is non-zero: Request_o <= 1, go to WAIT_GEN.
  - If the duration is zero: skip the generator and go directly to DONE.
- WAIT_GEN:
  - Request_o <= 0.
  - On GenDone_i high: go to DONE.
- DONE:
  - Done_o[W] <= 1 for exactly one cycle and Grant_o <= 0.
  - Round-robin pointer Last <= W.
  - Return to IDLE.
- Arbitration: circular search starting at Last+1. Last resets to 3, so requester 0 wins first.
- Req_i[W] high on the edge that grants W: this edge both clears the old pending bit and captures the new request, so Pending[W] stays set with the new parameters.
  - The tone issued on that edge uses the old buffered parameters.
- Requester n may re-post while granted. The tone is buffered because the generator copy lives in the output registers.
- Reset mid-tone: all state returns to reset values and pending tones are lost.
  - The generator shares the same Reset, so no orphan Done can occur.
- GenDone_i outside WAIT_GEN is ignored.

## Timing
- Reset values:
  - Pending_o = 0, Grant_o = 0, Done_o = 0, Request_o = 0.
  - Duration_ms_o = 0, HalfPeriod_us_o = 0.
  - State = IDLE, Last = 3.
- Request latency, with Req_i[n] sampled at edge k and the FSM idle:
  - Pending_o[n] = 1 after edge k.
  - Grant_o[n] = 1 and Request_o = 1 after edge k+1.
  - Request_o = 0 after edge k+2.
- Parameter outputs are stable from the Request_o edge until the next grant.
- Completion, with GenDone_i sampled at edge m:
  - Done_o[n] = 1 and Grant_o = 0 after edge m.
  - Done_o = 0 and IDLE after edge m+1.
  - The next Request_o is no earlier than edge m+2.
- Zero duration: Done_o pulses 2 edges after the grant edge, and Request_o is never asserted.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Configuration
- SOUND_ARBITER_FIXED_PRIORITY_EN:
  - When defined: the winner is the lowest-index pending requester. Last is not implemented, and requester 0 can starve the others.
  - When undefined: round-robin as described above.

## Test plan
- Single tone: Req_i=4'b0010 with Duration 1000 ms, HalfPeriod 500 µs → Request_o pulses once with 1000/500, Grant_o=4'b0010 until one cycle after GenDone_i, then a single Done_o[1] pulse.
- All four request simultaneously after reset → grant order 0,1,2,3. Re-request requester 1 while 3 plays → next grant is 1 (0 is skipped because it is not pending).
- Zero duration: Req_i[2] with Duration 0 → Done_o[2] two cycles after Grant_o[2] rises, Request_o stays 0, GenDone_i unused.
- Cancel: requester 3 pending while 0 plays, Cancel_i[3] plus Req_i[3] on the same edge → Pending_o[3]=0, no grant to 3; Cancel_i[0] does not disturb the playing tone.
- Reset asserted mid WAIT_GEN with requesters 1 and 2 pending → all outputs 0 asynchronously, nothing granted after release until a new Req_i.
- With SOUND_ARBITER_FIXED_PRIORITY_EN defined and requesters 0 and 2 continuously re-requesting → 0 always wins and 2 is never granted.
